// File: rtl/lcd_bus_pkg.sv
// Shared constants, state encoding and DDRAM address helpers for the LCD bus decoder.
package lcd_bus_pkg;

    localparam logic [7:0] CMD_CLEAR        = 8'h01;
    localparam logic [7:0] CMD_HOME         = 8'h02;
    localparam logic [7:0] CMD_HOME_MASK    = 8'hFE;
    localparam logic [7:0] CMD_DISPCTL_MASK = 8'hF8;
    localparam logic [7:0] CMD_DISPCTL_VAL  = 8'h08;
    localparam int         CMD_SETADDR_BIT  = 7;

    localparam logic [6:0] LINE1_BASE = 7'h00;
    localparam logic [6:0] LINE2_BASE = 7'h40;
    localparam int         LINE_LEN   = 16;
    localparam logic [6:0] LINE1_WRAP = 7'h27;
    localparam logic [6:0] LINE2_WRAP = 7'h67;
    localparam logic [6:0] LAST_ADDR  = LINE2_BASE + 7'(LINE_LEN - 1);

    localparam int SHADOW_LEN = 2 * LINE_LEN;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Only the first 16 columns of each line are shadowed: 0x00-0x0F and 0x40-0x4F.
    function automatic logic addr_visible(input logic [6:0] a);
        return (a[6:4] == 3'b000) || (a[6:4] == 3'b100);
    endfunction

    function automatic logic [4:0] shadow_idx(input logic [6:0] a);
        return {a[6], a[3:0]};
    endfunction

    function automatic logic [6:0] next_addr(input logic [6:0] a);
        if (a == LINE1_WRAP) return LINE2_BASE;
        if (a == LINE2_WRAP) return LINE1_BASE;
        return a + 7'd1;
    endfunction

endpackage

// File: rtl/lcd_bus_if.sv
// Character-LCD write bus as seen between the driver and the decoder.
interface lcd_bus_if;
    logic [7:0] lcd_data;
    logic       lcd_e;
    logic       lcd_rs;

    modport master (output lcd_data, output lcd_e, output lcd_rs);
    modport slave  (input  lcd_data, input  lcd_e, input  lcd_rs);
endinterface

// File: rtl/lcd_bus_sync.sv
// Synchronizes the LCD bus and emits a one-cycle strobe with rs/data on each enable falling edge.
module lcd_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       e_in,
    input  logic       rs_in,
    input  logic [7:0] data_in,
    output logic       strobe,
    output logic       rs,
    output logic [7:0] data
);

    logic [SYNC_STAGES-1:0]       e_sync;
    logic [SYNC_STAGES-1:0]       rs_sync;
    logic [SYNC_STAGES-1:0][7:0]  data_sync;
    logic                         e_prev;
    logic                         fall;

    assign fall = e_prev & ~e_sync[SYNC_STAGES-1];

    always_ff @(posedge Clk) begin
        if (!reset) begin
            e_sync    <= '0;
            rs_sync   <= '0;
            data_sync <= '0;
            e_prev    <= 1'b0;
            strobe    <= 1'b0;
            rs        <= 1'b0;
            data      <= '0;
        end else begin
            e_sync    <= {e_sync[SYNC_STAGES-2:0], e_in};
            rs_sync   <= {rs_sync[SYNC_STAGES-2:0], rs_in};
            data_sync <= {data_sync[SYNC_STAGES-2:0], data_in};
            e_prev    <= e_sync[SYNC_STAGES-1];
            strobe    <= fall;
            // rs/data travel through the same depth as e, so they are aligned on the detect cycle
            if (fall) begin
                rs   <= rs_sync[SYNC_STAGES-1];
                data <= data_sync[SYNC_STAGES-1];
            end
        end
    end

endmodule

// File: rtl/lcd_bus_decoder.sv
// HD44780-style bus receiver: decodes commands/data and keeps a 2x16 character shadow.
module lcd_bus_decoder
    import lcd_bus_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] CLEAR_CHAR  = 8'h20
) (
    input  logic       Clk,
    input  logic       reset,
    lcd_bus_if.slave   bus,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [6:0] cur_addr,
    output logic       display_on,
    output logic       busy,
    output logic       cmd_valid,
    output logic [7:0] cmd_byte,
    output logic       frame_done,
    output logic       protocol_err
);

    logic       cap_stb;
    logic       cap_rs;
    logic [7:0] cap_data;

    lcd_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .Clk     (Clk),
        .reset   (reset),
        .e_in    (bus.lcd_e),
        .rs_in   (bus.lcd_rs),
        .data_in (bus.lcd_data),
        .strobe  (cap_stb),
        .rs      (cap_rs),
        .data    (cap_data)
    );

    state_t     state, state_nxt;
    logic [4:0] clr_idx;

    logic       wr_en;
    logic [4:0] wr_idx;
    logic [7:0] wr_data;
    logic [6:0] addr_nxt;
    logic       disp_nxt;
    logic       cmd_v_nxt;
    logic [7:0] cmd_b_nxt;
    logic       frame_nxt;
    logic       err_set;

    logic [7:0] shadow [SHADOW_LEN];

    always_ff @(posedge Clk) begin
        if (!reset) begin
            state   <= ST_CLEAR;
            clr_idx <= '0;
        end else begin
            state   <= state_nxt;
            clr_idx <= (state == ST_CLEAR) ? clr_idx + 5'd1 : 5'd0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_CLEAR: if (clr_idx == 5'(SHADOW_LEN - 1)) state_nxt = ST_IDLE;
            ST_IDLE:  if (cap_stb && !cap_rs && cap_data == CMD_CLEAR) state_nxt = ST_CLEAR;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_en     = 1'b0;
        wr_idx    = '0;
        wr_data   = '0;
        addr_nxt  = cur_addr;
        disp_nxt  = display_on;
        cmd_v_nxt = 1'b0;
        cmd_b_nxt = cmd_byte;
        frame_nxt = 1'b0;
        err_set   = 1'b0;
        case (state)
            ST_CLEAR: begin
                wr_en    = 1'b1;
                wr_idx   = clr_idx;
                wr_data  = CLEAR_CHAR;
                addr_nxt = LINE1_BASE;
                // Anything landing during a clear, including the final cycle, is dropped
                err_set  = cap_stb;
            end
            ST_IDLE: begin
                if (cap_stb && !cap_rs) begin
                    cmd_v_nxt = 1'b1;
                    cmd_b_nxt = cap_data;
                    if (cap_data[CMD_SETADDR_BIT])
                        addr_nxt = cap_data[6:0];
                    else if (cap_data == CMD_CLEAR)
                        addr_nxt = LINE1_BASE;
                    else if ((cap_data & CMD_HOME_MASK) == CMD_HOME)
                        addr_nxt = LINE1_BASE;
                    else if ((cap_data & CMD_DISPCTL_MASK) == CMD_DISPCTL_VAL)
                        disp_nxt = cap_data[2];
                end else if (cap_stb) begin
                    if (addr_visible(cur_addr)) begin
                        wr_en   = 1'b1;
                        wr_idx  = shadow_idx(cur_addr);
                        wr_data = cap_data;
                    end else begin
                        err_set = 1'b1;
                    end
                    frame_nxt = (cur_addr == LAST_ADDR);
                    addr_nxt  = next_addr(cur_addr);
                end
            end
            default: ;
        endcase
    end

    assign busy = (state == ST_CLEAR);

    always_ff @(posedge Clk) begin
        if (!reset) begin
            cur_addr     <= '0;
            display_on   <= 1'b0;
            cmd_valid    <= 1'b0;
            cmd_byte     <= '0;
            frame_done   <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            cur_addr     <= addr_nxt;
            display_on   <= disp_nxt;
            cmd_valid    <= cmd_v_nxt;
            cmd_byte     <= cmd_b_nxt;
            frame_done   <= frame_nxt;
            protocol_err <= protocol_err | err_set;
        end
    end

    always_ff @(posedge Clk) begin
        if (reset && wr_en)
            shadow[wr_idx] <= wr_data;
    end

    always_ff @(posedge Clk) begin
        if (!reset)
            rd_data <= '0;
        else
            rd_data <= shadow[rd_addr];
    end

endmodule

// File: tb/tb_lcd_bus_decoder.sv
// Bench for lcd_bus_decoder: vector table, command scoreboard and multi-cycle corner sequences.
module tb_lcd_bus_decoder;

    logic       Clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic [6:0] cur_addr;
    logic       display_on;
    logic       busy;
    logic       cmd_valid;
    logic [7:0] cmd_byte;
    logic       frame_done;
    logic       protocol_err;

    always #5 Clk = ~Clk;

    lcd_bus_if bus();

    lcd_bus_decoder #(.SYNC_STAGES(2), .CLEAR_CHAR(8'h20)) dut (
        .Clk          (Clk),
        .reset        (reset),
        .bus          (bus),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .cur_addr     (cur_addr),
        .display_on   (display_on),
        .busy         (busy),
        .cmd_valid    (cmd_valid),
        .cmd_byte     (cmd_byte),
        .frame_done   (frame_done),
        .protocol_err (protocol_err)
    );

    int         checks = 0;
    int         failures = 0;
    int         cmd_pulses = 0;
    int         frame_cnt = 0;
    logic [7:0] exp_q [$];

    typedef struct {
        bit         rs;
        logic [7:0] data;
        int         addr;
        int         disp;
        int         frames;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted command must match the next one the bench expects
    always @(negedge Clk) begin
        if (reset === 1'b1) begin
            if (frame_done === 1'b1) frame_cnt++;
            if (cmd_valid === 1'b1) begin
                cmd_pulses++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected_cmd: got 0x%0h expected no command", cmd_byte);
                end else begin
                    chk("sb_cmd_byte", 32'(cmd_byte), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic lcd_write(input bit rs, input logic [7:0] d, input bit expect_cmd);
        @(negedge Clk);
        bus.lcd_rs   = rs;
        bus.lcd_data = d;
        bus.lcd_e    = 1'b1;
        if (expect_cmd) exp_q.push_back(d);
        repeat (2) @(negedge Clk);
        bus.lcd_e = 1'b0;
        repeat (6) @(negedge Clk);
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            @(negedge Clk);
            cyc++;
        end
        if (busy !== 1'b0) begin
            checks++;
            failures++;
            $display("FAIL busy_timeout: got busy=%0b expected 0 within 200 cycles", busy);
        end
    endtask

    task automatic read_chk(input int idx, input logic [7:0] exp);
        @(negedge Clk);
        rd_addr = 5'(idx);
        @(negedge Clk);
        chk($sformatf("rd[%0d]", idx), 32'(rd_data), 32'(exp));
    endtask

    task automatic release_and_count(input string name);
        int cnt;
        reset = 1'b1;
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge Clk);
        end
        chk(name, 32'(cnt), 32);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 50000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int f0;
        int p0;

        bus.lcd_e    = 1'b0;
        bus.lcd_rs   = 1'b0;
        bus.lcd_data = 8'h00;
        rd_addr      = '0;
        reset        = 1'b0;

        vecs[0]  = '{1'b0, 8'h38, 'h00, 0, 0};
        vecs[1]  = '{1'b0, 8'h06, 'h00, 0, 0};
        vecs[2]  = '{1'b0, 8'h0C, 'h00, 1, 0};
        vecs[3]  = '{1'b0, 8'h85, 'h05, 1, 0};
        vecs[4]  = '{1'b1, 8'h31, 'h06, 1, 0};
        vecs[5]  = '{1'b1, 8'h32, 'h07, 1, 0};
        vecs[6]  = '{1'b0, 8'h02, 'h00, 1, 0};
        vecs[7]  = '{1'b0, 8'h08, 'h00, 0, 0};
        vecs[8]  = '{1'b0, 8'h8F, 'h0F, 0, 0};
        vecs[9]  = '{1'b1, 8'h33, 'h10, 0, 0};
        vecs[10] = '{1'b0, 8'h03, 'h00, 0, 0};
        vecs[11] = '{1'b0, 8'h0E, 'h00, 1, 0};
        vecs[12] = '{1'b0, 8'hCF, 'h4F, 1, 0};
        vecs[13] = '{1'b1, 8'h34, 'h50, 1, 1};
        vecs[14] = '{1'b0, 8'h14, 'h50, 1, 0};

        // Reset state
        repeat (3) @(negedge Clk);
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_cur_addr", 32'(cur_addr), 0);
        chk("rst_display_on", 32'(display_on), 0);
        chk("rst_busy", 32'(busy), 1);
        chk("rst_cmd_valid", 32'(cmd_valid), 0);
        chk("rst_cmd_byte", 32'(cmd_byte), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_protocol_err", 32'(protocol_err), 0);
        release_and_count("busy_cycles_after_reset");
        for (int i = 0; i < 32; i++) read_chk(i, 8'h20);
        chk("cur_addr_after_clear", 32'(cur_addr), 0);

        // Vector table
        for (int i = 0; i < 15; i++) begin
            f0 = frame_cnt;
            lcd_write(vecs[i].rs, vecs[i].data, !vecs[i].rs);
            chk($sformatf("vec%0d_cur_addr", i), 32'(cur_addr), 32'(vecs[i].addr));
            chk($sformatf("vec%0d_display_on", i), 32'(display_on), 32'(vecs[i].disp));
            chk($sformatf("vec%0d_frames", i), 32'(frame_cnt - f0), 32'(vecs[i].frames));
        end
        read_chk(5, 8'h31);
        read_chk(6, 8'h32);
        read_chk(15, 8'h33);
        read_chk(31, 8'h34);
        chk("vec_protocol_err", 32'(protocol_err), 0);

        // Init sequence with clear, then "HI"
        p0 = cmd_pulses;
        lcd_write(1'b0, 8'h38, 1'b1);
        lcd_write(1'b0, 8'h06, 1'b1);
        lcd_write(1'b0, 8'h0C, 1'b1);
        lcd_write(1'b0, 8'h01, 1'b1);
        wait_idle(cyc);
        lcd_write(1'b1, 8'h48, 1'b0);
        lcd_write(1'b1, 8'h49, 1'b0);
        chk("init_cmd_pulses", 32'(cmd_pulses - p0), 4);
        chk("init_display_on", 32'(display_on), 1);
        read_chk(0, 8'h48);
        read_chk(1, 8'h49);
        read_chk(5, 8'h20);
        read_chk(31, 8'h20);
        chk("init_cur_addr", 32'(cur_addr), 2);

        // Full line 2, frame_done on the 16th byte only
        lcd_write(1'b0, 8'hC0, 1'b1);
        f0 = frame_cnt;
        for (int k = 0; k < 16; k++) begin
            lcd_write(1'b1, 8'(8'h41 + k), 1'b0);
            if (k == 14) chk("line2_no_early_frame", 32'(frame_cnt - f0), 0);
        end
        chk("line2_frame_once", 32'(frame_cnt - f0), 1);
        for (int k = 0; k < 16; k++) read_chk(16 + k, 8'(8'h41 + k));
        chk("line2_cur_addr", 32'(cur_addr), 'h50);
        chk("line2_protocol_err", 32'(protocol_err), 0);

        // Data and a second clear arriving during a clear are dropped
        lcd_write(1'b0, 8'h01, 1'b1);
        repeat (4) @(negedge Clk);
        lcd_write(1'b1, 8'h77, 1'b0);
        chk("busy_during_clear", 32'(busy), 1);
        chk("busy_write_err", 32'(protocol_err), 1);
        lcd_write(1'b0, 8'h01, 1'b0);
        wait_idle(cyc);
        chk("clear_not_restarted", 32'(cyc > 15), 0);
        for (int i = 0; i < 32; i++) read_chk(i, 8'h20);
        chk("busy_clear_cur_addr", 32'(cur_addr), 0);

        // Reset clears the sticky error
        reset = 1'b0;
        repeat (2) @(negedge Clk);
        reset = 1'b1;
        wait_idle(cyc);
        chk("err_cleared_by_reset", 32'(protocol_err), 0);

        // Hidden addresses: write dropped, wraps 0x27->0x40 and 0x67->0x00
        lcd_write(1'b0, 8'hA7, 1'b1);
        lcd_write(1'b1, 8'h5A, 1'b0);
        chk("hidden_err", 32'(protocol_err), 1);
        chk("wrap_27_cur_addr", 32'(cur_addr), 'h40);
        for (int i = 0; i < 32; i++) read_chk(i, 8'h20);
        lcd_write(1'b0, 8'hE7, 1'b1);
        lcd_write(1'b1, 8'h5B, 1'b0);
        chk("wrap_67_cur_addr", 32'(cur_addr), 'h00);
        read_chk(0, 8'h20);

        // Reset pulsed during the 5th byte of a line-1 write burst
        lcd_write(1'b0, 8'h80, 1'b1);
        for (int k = 0; k < 4; k++) lcd_write(1'b1, 8'(8'h61 + k), 1'b0);
        chk("burst_cur_addr", 32'(cur_addr), 4);
        read_chk(3, 8'h64);
        @(negedge Clk);
        bus.lcd_rs   = 1'b1;
        bus.lcd_data = 8'h65;
        bus.lcd_e    = 1'b1;
        @(negedge Clk);
        reset = 1'b0;
        @(negedge Clk);
        bus.lcd_e = 1'b0;
        repeat (3) @(negedge Clk);
        chk("midrst_cur_addr", 32'(cur_addr), 0);
        chk("midrst_busy", 32'(busy), 1);
        chk("midrst_protocol_err", 32'(protocol_err), 0);
        chk("midrst_cmd_byte", 32'(cmd_byte), 0);
        chk("midrst_display_on", 32'(display_on), 0);
        chk("midrst_rd_data", 32'(rd_data), 0);
        release_and_count("busy_cycles_after_midrst");
        for (int i = 0; i < 32; i++) read_chk(i, 8'h20);
        chk("midrst_err_after", 32'(protocol_err), 0);

        chk("sb_queue_drained", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
